rtc_bus_responder: RTL and testbench

- Device-side responder for the multiplexed AD/CS/RD/WR parallel bus driven by our bus timing controller.
- Decodes address phases (AD=0), write phases (AD=1, WR=0) and read phases (AD=1, RD=0) under CS=0.
- Holds a small register file and drives read data with an output-enable.
- Serves as the device model in system simulation and as the slave end when our FPGA is the bus target.
- A local port lets on-chip logic (e.g. timekeeping) read and update the register file.

---
 rtl/rtc_bus_pkg.sv | 46 ++++
 rtl/rtc_bus_sync.sv | 104 ++++++++++
 rtl/rtc_bus_responder.sv | 191 +++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the multiplexed AD/CS/RD/WR bus responder.
//   - Default bus width and register count, plus the synchronizer depth.
//   - FSM state encoding.
//   - Phase-pattern encoding and a classifier that maps the synchronized
//     strobes to a pattern.
package rtc_bus_pkg;

  localparam int DATA_W      = 8;
  localparam int NREGS       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LOC_ADDR_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_PH,
    WR_PH,
    RD_PH,
    ERR
  } state_e;

  // The pattern seen on the synchronized strobes in one cycle. All strobes
  // except AD are active low.
  typedef enum logic [2:0] {
    PAT_NONE,
    PAT_ADDR,  // CS=0, WR=0, RD=1, AD=0
    PAT_WR,    // CS=0, WR=0, RD=1, AD=1
    PAT_RD,    // CS=0, RD=0, WR=1, AD=1
    PAT_BOTH   // CS=0, RD=0, WR=0 (protocol error)
  } phase_pat_e;

  function automatic phase_pat_e classify_phase(input logic cs_n, input logic ad,
                                                input logic rd_n, input logic wr_n);
    phase_pat_e pat;
    pat = PAT_NONE;
    if (!cs_n) begin
      case ({rd_n, wr_n})
        2'b10:   pat = ad ? PAT_WR : PAT_ADDR;
        2'b01:   pat = ad ? PAT_RD : PAT_NONE;  // read with AD=0 is not a phase
        2'b00:   pat = PAT_BOTH;
        default: pat = PAT_NONE;
      endcase
    end
    return pat;
  endfunction

endpackage

// File: rtl/rtc_bus_sync.sv
// Input conditioning for the bus responder.
//   - Two-flop synchronizers on AD/CS/RD/WR (reset to the inactive level 1).
//   - Matching delay line on bus_in so data stays aligned with the strobes.
//   - Stability counter: a phase pattern qualifies only after it has held
//     for MIN_LOW consecutive synchronized cycles.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_ad/in_cs/in_rd/in_wr  raw bus strobes
//   bus_in                   raw bus value
//   bus_s                    bus value aligned with the synchronized strobes
//   cs_s                     synchronized chip select (active low)
//   cs_rise                  one-cycle pulse on synchronized CS rising
//   qual_addr/wr/rd/both     qualified phase patterns (mutually exclusive)
module rtc_bus_sync #(
  parameter int DATA_W  = rtc_bus_pkg::DATA_W,
  parameter int MIN_LOW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ad,
  input  logic              in_cs,
  input  logic              in_rd,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_s,
  output logic              cs_s,
  output logic              cs_rise,
  output logic              qual_addr,
  output logic              qual_wr,
  output logic              qual_rd,
  output logic              qual_both
);
  import rtc_bus_pkg::*;

  localparam logic [2:0] RUN_MAX = 3'(MIN_LOW);

  logic [SYNC_STAGES-1:0] ad_sq, cs_sq, rd_sq, wr_sq;
  logic [DATA_W-1:0]      bus_dq [SYNC_STAGES];
  logic                   ad_s, rd_s, wr_s;
  logic                   cs_prev_q;
  phase_pat_e             pat_now, pat_q;
  logic [2:0]             run_d, run_q;
  logic                   qualified;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_sq <= '1;
      cs_sq <= '1;
      rd_sq <= '1;
      wr_sq <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) bus_dq[i] <= '0;
      cs_prev_q <= 1'b1;
      pat_q     <= PAT_NONE;
      run_q     <= '0;
    end else begin
      ad_sq <= {ad_sq[SYNC_STAGES-2:0], in_ad};
      cs_sq <= {cs_sq[SYNC_STAGES-2:0], in_cs};
      rd_sq <= {rd_sq[SYNC_STAGES-2:0], in_rd};
      wr_sq <= {wr_sq[SYNC_STAGES-2:0], in_wr};
      bus_dq[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) bus_dq[i] <= bus_dq[i-1];
      cs_prev_q <= cs_s;
      pat_q     <= pat_now;
      run_q     <= run_d;
    end
  end

  assign ad_s  = ad_sq[SYNC_STAGES-1];
  assign cs_s  = cs_sq[SYNC_STAGES-1];
  assign rd_s  = rd_sq[SYNC_STAGES-1];
  assign wr_s  = wr_sq[SYNC_STAGES-1];
  assign bus_s = bus_dq[SYNC_STAGES-1];

  assign pat_now = classify_phase(cs_s, ad_s, rd_s, wr_s);

  // run_d is the length of the current run including this cycle, saturated
  // at MIN_LOW so a long phase cannot wrap the counter.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    run_d = '0;
    if (pat_now == PAT_NONE) begin
      run_d = '0;
    end else if (pat_now != pat_q) begin
      run_d = 3'd1;
    end else if (run_q < RUN_MAX) begin
      run_d = run_q + 3'd1;
    end else begin
      run_d = run_q;
    end
  end

  assign qualified = (pat_now != PAT_NONE) && (run_d >= RUN_MAX);
  assign qual_addr = qualified && (pat_now == PAT_ADDR);
  assign qual_wr   = qualified && (pat_now == PAT_WR);
  assign qual_rd   = qualified && (pat_now == PAT_RD);
  assign qual_both = qualified && (pat_now == PAT_BOTH);

  assign cs_rise = cs_s & ~cs_prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Device-side responder for the multiplexed AD/CS/RD/WR parallel bus.
// Decodes address, write and read phases, holds a small register file,
// drives read data with an output enable, and offers a local port for
// on-chip logic to read and update the registers.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_ad/in_cs/in_rd/in_wr  bus strobes (CS/RD/WR active low, AD=0 address)
//   bus_in                   bus value from the controller
//   bus_out, bus_oe          read data and drive enable toward the bus
//   loc_addr/loc_we/loc_wdata  local register access
//   loc_rdata                registered read of reg[loc_addr]
//   wr_strobe, rd_strobe     one-cycle pulses on bus write commit / read end
//   err                      one-cycle pulse on protocol or address error
module rtc_bus_responder #(
  parameter int DATA_W  = rtc_bus_pkg::DATA_W,
  parameter int NREGS   = rtc_bus_pkg::NREGS,
  parameter int MIN_LOW = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_ad,
  input  logic                              in_cs,
  input  logic                              in_rd,
  input  logic                              in_wr,
  input  logic [DATA_W-1:0]                 bus_in,
  output logic [DATA_W-1:0]                 bus_out,
  output logic                              bus_oe,
  input  logic [rtc_bus_pkg::LOC_ADDR_W-1:0] loc_addr,
  input  logic                              loc_we,
  input  logic [DATA_W-1:0]                 loc_wdata,
  output logic [DATA_W-1:0]                 loc_rdata,
  output logic                              wr_strobe,
  output logic                              rd_strobe,
  output logic                              err
);
  import rtc_bus_pkg::*;

  localparam int              IDX_W   = $clog2(NREGS);
  localparam logic [DATA_W:0] NREGS_W = (DATA_W+1)'(NREGS);

  logic [DATA_W-1:0] bus_s;
  logic              cs_s, cs_rise;
  logic              qual_addr, qual_wr, qual_rd, qual_both;

  state_e            state_q;
  logic [DATA_W-1:0] addr_q;
  logic              addr_valid_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] bus_out_q;
  logic              bus_oe_q;
  logic              wr_strobe_q, rd_strobe_q, err_q;
  logic [DATA_W-1:0] loc_rdata_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [IDX_W-1:0]  addr_idx;
  logic              addr_ok;
  logic              commit_wr;

  rtc_bus_sync #(
    .DATA_W  (DATA_W),
    .MIN_LOW (MIN_LOW)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .in_ad     (in_ad),
    .in_cs     (in_cs),
    .in_rd     (in_rd),
    .in_wr     (in_wr),
    .bus_in    (bus_in),
    .bus_s     (bus_s),
    .cs_s      (cs_s),
    .cs_rise   (cs_rise),
    .qual_addr (qual_addr),
    .qual_wr   (qual_wr),
    .qual_rd   (qual_rd),
    .qual_both (qual_both)
  );

  // Full-width compare: addresses at or above NREGS never alias onto a
  // low register.
  assign addr_ok   = addr_valid_q && ({1'b0, addr_q} < NREGS_W);
  assign addr_idx  = addr_q[IDX_W-1:0];
  assign commit_wr = (state_q == WR_PH) && !qual_both && cs_rise && addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      sample_q     <= '0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      rd_strobe_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      err_q       <= 1'b0;

      // Only samples taken while CS is low are kept, so on the CS-rise
      // cycle sample_q still holds the last value of the phase.
      if (!cs_s) sample_q <= bus_s;

      unique case (state_q)
        IDLE: begin
          bus_oe_q  <= 1'b0;
          bus_out_q <= '0;
          if (qual_addr) begin
            state_q <= ADDR_PH;
          end else if (qual_wr) begin
            state_q <= WR_PH;
          end else if (qual_rd) begin
            state_q <= RD_PH;
            if (!addr_ok) err_q <= 1'b1;
          end else if (qual_both) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end
        end

        ADDR_PH: begin
          if (cs_rise) begin
            addr_q       <= sample_q;
            addr_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end

        WR_PH: begin
          if (qual_both) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else if (cs_rise) begin
            if (commit_wr) wr_strobe_q <= 1'b1;
            else           err_q       <= 1'b1;
            state_q <= IDLE;
          end
        end

        RD_PH: begin
          if (qual_both) begin
            err_q     <= 1'b1;
            bus_oe_q  <= 1'b0;
            bus_out_q <= '0;
            state_q   <= ERR;
          end else if (cs_rise) begin
            bus_oe_q    <= 1'b0;
            bus_out_q   <= '0;
            rd_strobe_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            bus_oe_q  <= 1'b1;
            bus_out_q <= addr_ok ? regs_q[addr_idx] : '0;
          end
        end

        ERR: begin
          bus_oe_q  <= 1'b0;
          bus_out_q <= '0;
          if (cs_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the register file is cleared by the async reset because software
  // relies on reading zeros after reset; this keeps it in flops rather than
  // a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      loc_rdata_q <= '0;
    end else begin
      if (commit_wr) regs_q[addr_idx] <= sample_q;
      // A bus commit to the same index takes priority over the local write.
      if (loc_we && !(commit_wr && (addr_idx == loc_addr))) regs_q[loc_addr] <= loc_wdata;
      loc_rdata_q <= regs_q[loc_addr];
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign loc_rdata = loc_rdata_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Strobe pulses are tallied on the
// falling edge so single-pulse behaviour can be confirmed over a window.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_ad = 1'b1, in_cs = 1'b1, in_rd = 1'b1, in_wr = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [3:0] loc_addr = 4'd0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_wdata = 8'h00;
  logic [7:0] loc_rdata;
  logic       wr_strobe, rd_strobe, err;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int wr_seen = 0, rd_seen = 0, err_seen = 0;
  int wr0, rd0, err0;

  rtc_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .in_ad     (in_ad),
    .in_cs     (in_cs),
    .in_rd     (in_rd),
    .in_wr     (in_wr),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .loc_addr  (loc_addr),
    .loc_we    (loc_we),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_seen++;
    if (rd_strobe === 1'b1) rd_seen++;
    if (err === 1'b1)       err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the falling edge where the pins go low.
  task automatic start_phase(input logic ad, input logic rd_n, input logic wr_n,
                             input logic [7:0] data);
    @(negedge clk);
    in_ad  = ad;
    in_rd  = rd_n;
    in_wr  = wr_n;
    bus_in = data;
    in_cs  = 1'b0;
  endtask

  // Returns on the falling edge where CS rises.
  task automatic end_phase();
    @(negedge clk);
    in_cs = 1'b1;
    in_rd = 1'b1;
    in_wr = 1'b1;
  endtask

  task automatic full_phase(input logic ad, input logic rd_n, input logic wr_n,
                            input logic [7:0] data, input int n_low);
    start_phase(ad, rd_n, wr_n, data);
    wait_neg(n_low - 1);
    end_phase();
    wait_neg(6);
  endtask

  task automatic read_loc(input logic [3:0] idx, input logic [7:0] exp, input string tag);
    @(negedge clk);
    loc_addr = idx;
    @(negedge clk);
    check(tag, loc_rdata, exp);
  endtask

  // Write phase whose commit coincides with a local write of 0x99 to loc_idx.
  task automatic write_with_local(input logic [7:0] data, input logic [3:0] loc_idx,
                                  input string tag);
    start_phase(1'b1, 1'b1, 1'b0, data);
    wait_neg(18);
    end_phase();
    wait_neg(2);
    loc_we    = 1'b1;
    loc_addr  = loc_idx;
    loc_wdata = 8'h99;
    @(negedge clk);
    check({tag, "_wr_strobe"}, wr_strobe, 1);
    loc_we = 1'b0;
    wait_neg(6);
  endtask

  initial begin
    // Reset state.
    wait_neg(3);
    check("rst_bus_oe", bus_oe, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    check("rst_strobes", {wr_strobe, rd_strobe, err}, 0);
    rst = 1'b0;
    wait_neg(3);

    // Address 0x05 then write 0xA7; wr_strobe three edges after CS rises.
    full_phase(1'b0, 1'b1, 1'b0, 8'h05, 19);
    wr0 = wr_seen; err0 = err_seen;
    start_phase(1'b1, 1'b1, 1'b0, 8'hA7);
    wait_neg(18);
    end_phase();
    @(negedge clk); check("wr_lat_edge1", wr_strobe, 0);
    @(negedge clk); check("wr_lat_edge2", wr_strobe, 0);
    @(negedge clk); check("wr_lat_edge3", wr_strobe, 1);
    check("wr_no_err", err, 0);
    @(negedge clk); check("wr_pulse_end", wr_strobe, 0);
    wait_neg(6);
    check("wr_one_pulse", wr_seen - wr0, 1);
    check("wr_err_count", err_seen - err0, 0);
    read_loc(4'd5, 8'hA7, "loc_reg5_after_wr");

    // Read back 0xA7 over the bus.
    rd0 = rd_seen; err0 = err_seen;
    start_phase(1'b1, 1'b0, 1'b1, 8'h00);
    wait_neg(8);
    check("rd_oe", bus_oe, 1);
    check("rd_data", bus_out, 8'hA7);
    end_phase();
    wait_neg(2);
    check("rd_oe_held", bus_oe, 1);
    @(negedge clk);
    check("rd_oe_drop", bus_oe, 0);
    check("rd_out_drop", bus_out, 0);
    check("rd_strobe", rd_strobe, 1);
    wait_neg(6);
    check("rd_one_pulse", rd_seen - rd0, 1);
    check("rd_err_count", err_seen - err0, 0);
    read_loc(4'd5, 8'hA7, "loc_reg5_after_rd");

    // Out-of-range address 0x20: write is rejected, read returns zero.
    full_phase(1'b0, 1'b1, 1'b0, 8'h20, 19);
    wr0 = wr_seen; err0 = err_seen;
    full_phase(1'b1, 1'b1, 1'b0, 8'h11, 19);
    check("bad_wr_no_strobe", wr_seen - wr0, 0);
    check("bad_wr_err_once", err_seen - err0, 1);
    read_loc(4'd0, 8'h00, "bad_wr_no_alias");
    read_loc(4'd5, 8'hA7, "bad_wr_reg5_kept");
    err0 = err_seen;
    start_phase(1'b1, 1'b0, 1'b1, 8'h00);
    wait_neg(4);
    check("bad_rd_err_entry", err, 1);
    wait_neg(4);
    check("bad_rd_oe", bus_oe, 1);
    check("bad_rd_data", bus_out, 8'h00);
    end_phase();
    wait_neg(6);
    check("bad_rd_err_once", err_seen - err0, 1);

    // One-cycle glitch must not qualify as an address phase.
    full_phase(1'b0, 1'b1, 1'b0, 8'h05, 19);
    wr0 = wr_seen; rd0 = rd_seen; err0 = err_seen;
    start_phase(1'b0, 1'b1, 1'b0, 8'h03);
    end_phase();
    wait_neg(6);
    check("glitch_wr", wr_seen - wr0, 0);
    check("glitch_rd", rd_seen - rd0, 0);
    check("glitch_err", err_seen - err0, 0);
    full_phase(1'b1, 1'b1, 1'b0, 8'h42, 19);
    check("glitch_then_wr", wr_seen - wr0, 1);
    read_loc(4'd5, 8'h42, "glitch_addr_kept");
    read_loc(4'd3, 8'h00, "glitch_reg3_clean");

    // RD and WR low together for three cycles.
    wr0 = wr_seen; rd0 = rd_seen; err0 = err_seen;
    start_phase(1'b1, 1'b0, 1'b0, 8'h00);
    wait_neg(2);
    end_phase();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("both_low_no_oe", bus_oe, 0);
    end
    wait_neg(2);
    check("both_low_err_once", err_seen - err0, 1);
    check("both_low_no_wr", wr_seen - wr0, 0);
    check("both_low_no_rd", rd_seen - rd0, 0);

    // Bus and local write collide on index 3: bus wins.
    full_phase(1'b0, 1'b1, 1'b0, 8'h03, 19);
    write_with_local(8'h55, 4'd3, "same_idx");
    read_loc(4'd3, 8'h55, "same_idx_bus_wins");
    // Different indices: both land.
    write_with_local(8'h55, 4'd4, "diff_idx");
    read_loc(4'd3, 8'h55, "diff_idx_reg3");
    read_loc(4'd4, 8'h99, "diff_idx_reg4");

    // Short reset pulse in the middle of a read phase.
    start_phase(1'b1, 1'b0, 1'b1, 8'h00);
    wait_neg(8);
    check("pre_rst_oe", bus_oe, 1);
    check("pre_rst_data", bus_out, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_oe", bus_oe, 0);
    check("mid_rst_out", bus_out, 0);
    rst = 1'b0;
    end_phase();
    wait_neg(6);
    read_loc(4'd3, 8'h00, "post_rst_reg3");
    read_loc(4'd4, 8'h00, "post_rst_reg4");
    err0 = err_seen;
    start_phase(1'b1, 1'b0, 1'b1, 8'h00);
    wait_neg(4);
    check("post_rst_rd_err", err, 1);
    wait_neg(4);
    check("post_rst_rd_data", bus_out, 8'h00);
    end_phase();
    wait_neg(6);
    check("post_rst_err_once", err_seen - err0, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
